conv3x3_engine: RTL and testbench
=================================

Name: conv3x3_engine

Overview:
Parametrised 3x3 neighbourhood filter engine. It reads a greyscale frame from a source BRAM port and writes the filtered frame to a separate destination BRAM port, so the top level keeps two memories in ping-pong.
- Supports four runtime-selectable kernels.
- Border pixels use replicate clamping, so every pixel is filtered.
- A sliding window reuses six of the nine taps from pixel to pixel.
- Start/busy/done/abort handshake for the keyboard-driven control FSM in top.

Parameters:
PIX_W, 8, pixel bit width
IMG_W, 256, frame width in pixels (>=2)
IMG_H, 256, frame height in pixels (>=2)
ADDR_W, 16, BRAM address width; IMG_W*IMG_H <= 2**ADDR_W
RD_LAT, 1, source BRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock (100 MHz)
btnC  in  1  reset, asynchronous, active-low (top drives it already inverted from the button)
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  cancel the run in progress
mode  in  2  kernel select: 0 copy, 1 box blur, 2 sharpen, 3 edge; latched when start is accepted
busy  out  1  high from start acceptance until the cycle done pulses
done  out  1  one-cycle pulse after the last pixel is written
src_addr  out  ADDR_W  source read address
src_dout  in  PIX_W  source read data, valid RD_LAT cycles after src_addr
dst_we  out  1  destination write enable
dst_addr  out  ADDR_W  destination write address
dst_din  out  PIX_W  destination write data

Behaviour:
- Reset (async, btnC=0): all outputs 0; FSM to IDLE; window registers cleared.
- Address mapping: addr = y*IMG_W + x; pixels are processed in raster order.
- Clamping: a tap coordinate of -1 maps to 0, and IMG_W (or IMG_H) maps to IMG_W-1 (or IMG_H-1).
- States:
  - IDLE → PRIME on start & !abort.
  - PRIME: issue 9 reads, one per cycle, for columns x-1, x, x+1 (rows y-1, y, y+1 each), then go to WAIT.
  - WAIT: RD_LAT cycles for the last read to return, then go to CALC.
  - CALC: 1 cycle; the kernel result is registered.
  - WRITE: 1 cycle with dst_we=1 at (x,y); then go to SHIFT if x<IMG_W-1, PRIME at the next row start, or FIN after the last pixel.
  - SHIFT: shift the window left one column, then issue 3 reads for column x+2 (clamped); then go to WAIT.
  - FIN: done=1 for one cycle, busy=0; return to IDLE.
- Read data is captured RD_LAT cycles after issue, into a tap index carried alongside the issue.
- Cycle cost: a row-start pixel takes 9+RD_LAT+2 cycles; every other pixel takes 3+RD_LAT+2.
- Kernel arithmetic, with taps p0..p8 in row-major order and p4 the centre:
  - Copy: p4.
  - Box: sum of the nine taps, PIX_W+4 bits wide; result = (sum*57)>>9.
  - Sharpen: 5*p4 - (p1+p3+p5+p7), computed signed, clamped to [0, 2**PIX_W-1].
  - Edge: gx = (p2+2p5+p8)-(p0+2p3+p6) and gy = (p6+2p7+p8)-(p0+2p1+p2); result = |gx|+|gy|, clamped to 2**PIX_W-1.
- Handshake:
  - start while busy is ignored.
  - abort has priority over start in the same cycle.
  - abort while busy: the next state is IDLE, dst_we drops the following cycle, done does not pulse, and writes already made stay in dst.
- mode changes mid-run have no effect until the next start.
- Reset mid-run: outputs go to 0 immediately, and dst_we must never glitch high.

Decomposition:
- Package conv3x3_pkg holds:
  - mode encodings (MODE_COPY/BOX/SHARP/EDGE);
  - BOX_MUL=57 and BOX_SHIFT=9;
  - the FSM state enum;
  - a clamp function.
- Sub-module conv3x3_alu: purely combinational; takes the nine taps and mode and returns a PIX_W result. The engine registers its output in CALC.

Test Plan:
- W=H=4, RD_LAT=1, ramp src[a]=a, mode 0 → dst[a]=a for all 16 pixels; done exactly 120 cycles after start acceptance; busy high for those cycles.
- All-255 frame, mode 1 → every dst pixel = 255, including corners via clamping; all-0 frame → 0.
- 4x4 zeros with src(1,1)=40, mode 2 → dst(1,1)=200; dst(0,1), dst(1,0), dst(2,1), dst(1,2) = 0 (clamped from -40); others = 0.
- Vertical step with columns 0-1 = 0 and columns 2-3 = 100, mode 3 → x=1 and x=2 give 255 (400 clamped), x=0 and x=3 give 0.
- abort asserted during the 5th pixel's WAIT → no further dst_we, no done pulse, busy low the next cycle; a new start then runs cleanly to done.
- btnC pulsed low mid-run → outputs 0 asynchronously; start while busy and start+abort together in IDLE are both ignored.

Source files
------------

// File: rtl/conv3x3_pkg.sv
// Shared definitions for the 3x3 neighbourhood filter engine:
// kernel encodings, box-blur constants, FSM states and coordinate clamping.
package conv3x3_pkg;

    localparam logic [1:0] MODE_COPY  = 2'd0;
    localparam logic [1:0] MODE_BOX   = 2'd1;
    localparam logic [1:0] MODE_SHARP = 2'd2;
    localparam logic [1:0] MODE_EDGE  = 2'd3;

    // (sum*57)>>9 approximates sum/9 closely enough to keep a flat frame flat
    localparam int BOX_MUL   = 57;
    localparam int BOX_SHIFT = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT,
        ST_CALC,
        ST_WRITE,
        ST_SHIFT,
        ST_FIN
    } state_e;

    // Replicate-border clamp of a tap coordinate into [0, lim-1]
    function automatic int clamp(input int v, input int lim);
        if (v < 0)    return 0;
        if (v >= lim) return lim - 1;
        return v;
    endfunction

endpackage

// File: rtl/conv3x3_alu.sv
// Combinational 3x3 kernel evaluation on taps p0..p8 (row-major, p4 centre).
// Intermediates are signed and wide enough that no kernel overflows before saturation.
module conv3x3_alu
    import conv3x3_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [8:0][PIX_W-1:0] taps_i,
    input  logic [1:0]            mode_i,
    output logic [PIX_W-1:0]      pix_o
);

    localparam int SW = PIX_W + 12;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << PIX_W) - 1);
    localparam logic signed [SW-1:0] BMUL = SW'(BOX_MUL);

    logic signed [SW-1:0] p [9];
    logic signed [SW-1:0] tsum, box, sharp, gx, gy, mag;

    function automatic logic [PIX_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v < 0)    return '0;
        if (v > MAXV) return '1;
        return v[PIX_W-1:0];
    endfunction

    always_comb begin
        tsum = '0;
        for (int i = 0; i < 9; i++) begin
            p[i] = $signed({{(SW-PIX_W){1'b0}}, taps_i[i]});
            tsum = tsum + p[i];
        end
        box   = (tsum * BMUL) >>> BOX_SHIFT;
        sharp = (p[4] <<< 2) + p[4] - (p[1] + p[3] + p[5] + p[7]);
        gx    = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
        gy    = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
        mag   = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        case (mode_i)
            MODE_COPY:  pix_o = taps_i[4];
            MODE_BOX:   pix_o = sat(box);
            MODE_SHARP: pix_o = sat(sharp);
            default:    pix_o = sat(mag);
        endcase
    end

endmodule

// File: rtl/conv3x3_engine.sv
// Raster-order 3x3 filter: primes a full window at each row start, then slides
// it one column per pixel, fetching only the new right-hand column.
module conv3x3_engine
    import conv3x3_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              btnC,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_dout,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_din
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic [1:0]               mode_q, mode_d;
    logic [8:0][PIX_W-1:0]    win_q, win_d;
    logic [RD_LAT-1:0]        vld_pipe_q;
    logic [RD_LAT-1:0][3:0]   idx_pipe_q;
    logic                     busy_q, done_q, we_q;
    logic [ADDR_W-1:0]        daddr_q;
    logic [PIX_W-1:0]         din_q;

    logic                     issue;
    logic [3:0]               issue_idx;
    int                       rd_x, rd_y, k;
    logic [PIX_W-1:0]         alu_pix;

    conv3x3_alu #(.PIX_W(PIX_W)) u_alu (
        .taps_i (win_q),
        .mode_i (mode_q),
        .pix_o  (alu_pix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        mode_d    = mode_q;
        issue     = 1'b0;
        issue_idx = '0;
        k         = int'(cnt_q);
        rd_x      = 0;
        rd_y      = 0;
        win_d     = win_q;
        case (state_q)
            ST_IDLE: if (start && !abort) begin
                state_d = ST_PRIME;
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
                mode_d  = mode;
            end
            // Column-major fetch of the full 3x3 window
            ST_PRIME: begin
                issue     = 1'b1;
                rd_x      = int'(x_q) - 1 + k / 3;
                rd_y      = int'(y_q) - 1 + k % 3;
                issue_idx = 4'((k % 3) * 3 + k / 3);
                if (cnt_q == 4'd8) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'(RD_LAT - 1)) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CALC: state_d = ST_WRITE;
            ST_WRITE: begin
                cnt_d = '0;
                if (int'(x_q) < IMG_W - 1) begin
                    state_d = ST_SHIFT;
                    x_d     = x_q + 1'b1;
                end else if (int'(y_q) < IMG_H - 1) begin
                    state_d = ST_PRIME;
                    x_d     = '0;
                    y_d     = y_q + 1'b1;
                end else begin
                    state_d = ST_FIN;
                end
            end
            // x already points at the new centre; fetch its right-hand column
            ST_SHIFT: begin
                issue     = 1'b1;
                rd_x      = int'(x_q) + 1;
                rd_y      = int'(y_q) - 1 + k;
                issue_idx = 4'(k * 3 + 2);
                if (cnt_q == 4'd0) begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[3*r]   = win_q[3*r+1];
                        win_d[3*r+1] = win_q[3*r+2];
                    end
                end
                if (cnt_q == 4'd2) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE)
            state_d = ST_IDLE;
        if (vld_pipe_q[RD_LAT-1])
            win_d[idx_pipe_q[RD_LAT-1]] = src_dout;
    end

    assign src_addr = issue ? ADDR_W'(clamp(rd_y, IMG_H) * IMG_W + clamp(rd_x, IMG_W)) : '0;

    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= '0;
            win_q      <= '0;
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            daddr_q    <= '0;
            din_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            win_q   <= win_d;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end
            vld_pipe_q[0] <= issue;
            idx_pipe_q[0] <= issue_idx;
            // Drop in-flight read tags so a restart never sees stale data
            if (state_d == ST_IDLE)
                vld_pipe_q <= '0;
            busy_q <= !(state_d inside {ST_IDLE, ST_FIN});
            done_q <= (state_d == ST_FIN);
            we_q   <= (state_d == ST_WRITE);
            if (state_q == ST_CALC && state_d == ST_WRITE) begin
                din_q   <= alu_pix;
                daddr_q <= ADDR_W'(int'(y_q) * IMG_W + int'(x_q));
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dst_we   = we_q;
    assign dst_addr = daddr_q;
    assign dst_din  = din_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine on a 4x4 frame with 1-cycle source BRAM;
// expected pixels come from a direct neighbourhood model of each kernel.
module tb_conv3x3_engine;

    localparam int PIX_W  = 8;
    localparam int W      = 4;
    localparam int H      = 4;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 1;
    localparam int NPIX   = W * H;

    logic              clk = 1'b0;
    logic              btnC = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              busy, done, dst_we;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [PIX_W-1:0]  src_dout, dst_din;

    int src_mem [NPIX];
    int dst_mem [NPIX];
    int wr_epoch [NPIX];
    int epoch = 0;
    int wr_cnt = 0;
    int rst_we_cnt = 0;
    int total = 0;
    int bad = 0;

    conv3x3_engine #(
        .PIX_W(PIX_W), .IMG_W(W), .IMG_H(H), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .btnC(btnC), .start(start), .abort(abort), .mode(mode),
        .busy(busy), .done(done), .src_addr(src_addr), .src_dout(src_dout),
        .dst_we(dst_we), .dst_addr(dst_addr), .dst_din(dst_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) src_dout <= PIX_W'(src_mem[int'(src_addr) % NPIX]);

    always @(posedge clk) begin
        if (dst_we) begin
            if (int'(dst_addr) < NPIX) begin
                dst_mem[dst_addr]  <= int'(dst_din);
                wr_epoch[dst_addr] <= epoch;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (!btnC && dst_we) rst_we_cnt <= rst_we_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pix(input int x, input int y);
        int xc, yc;
        xc = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
        yc = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
        return src_mem[yc * W + xc];
    endfunction

    function automatic int ref_pix(input int m, input int x, input int y);
        int t [9];
        int s, gx, gy, v;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                t[(dy + 1) * 3 + dx + 1] = pix(x + dx, y + dy);
        case (m)
            0: v = t[4];
            1: begin
                s = 0;
                foreach (t[i]) s += t[i];
                v = (s * 57) / 512;
            end
            2: v = 5 * t[4] - (t[1] + t[3] + t[5] + t[7]);
            default: begin
                gx = (t[2] + 2 * t[5] + t[8]) - (t[0] + 2 * t[3] + t[6]);
                gy = (t[6] + 2 * t[7] + t[8]) - (t[0] + 2 * t[1] + t[2]);
                v  = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
            end
        endcase
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    // Issue a start and follow the run to done; k counts edges after acceptance
    task automatic run_frame(input int m, output int cyc, output int busy_cyc);
        @(negedge clk);
        mode  = 2'(m);
        start = 1'b1;
        epoch++;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 2000) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({busy, done, dst_we} !== 3'b000 || src_addr !== '0 || dst_addr !== '0 || dst_din !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b src=%0d dst=%0d din=%0d, want all 0",
                     busy, done, dst_we, src_addr, dst_addr, dst_din);
        end
        repeat (2) @(negedge clk);
        btnC = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, dst_we} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: busy/done/we=%b want 000", {busy, done, dst_we});
        end
    endtask

    task automatic test_copy_timing();
        int cyc, bc, base;
        foreach (src_mem[a]) src_mem[a] = a;
        base = wr_cnt;
        run_frame(0, cyc, bc);
        total++;
        if (cyc !== 120) begin bad++; $display("FAIL copy_latency: got %0d want 120", cyc); end
        total++;
        if (bc !== 120) begin bad++; $display("FAIL copy_busy_cycles: got %0d want 120", bc); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL copy_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL copy_done_pulse: got %b want 0", done); end
        total++;
        if (wr_cnt - base !== NPIX) begin bad++; $display("FAIL copy_writes: got %0d want %0d", wr_cnt - base, NPIX); end
        for (int a = 0; a < NPIX; a++) begin
            total++;
            if (dst_mem[a] !== a || wr_epoch[a] !== epoch) begin
                bad++;
                $display("FAIL copy_pix[%0d]: got %0d want %0d", a, dst_mem[a], a);
            end
        end
    endtask

    task automatic test_box();
        int cyc, bc;
        for (int f = 0; f < 2; f++) begin
            foreach (src_mem[a]) src_mem[a] = (f == 0) ? 255 : 0;
            run_frame(1, cyc, bc);
            total++;
            if (cyc !== 120) begin bad++; $display("FAIL box_latency: got %0d want 120", cyc); end
            for (int a = 0; a < NPIX; a++) begin
                total++;
                if (dst_mem[a] !== ((f == 0) ? 255 : 0) || wr_epoch[a] !== epoch) begin
                    bad++;
                    $display("FAIL box_flat%0d[%0d]: got %0d want %0d", f, a, dst_mem[a], (f == 0) ? 255 : 0);
                end
            end
        end
    endtask

    task automatic test_sharpen();
        int cyc, bc;
        foreach (src_mem[a]) src_mem[a] = 0;
        src_mem[1 * W + 1] = 40;
        run_frame(2, cyc, bc);
        for (int a = 0; a < NPIX; a++) begin
            total++;
            if (dst_mem[a] !== ((a == 5) ? 200 : 0) || wr_epoch[a] !== epoch) begin
                bad++;
                $display("FAIL sharpen_pix[%0d]: got %0d want %0d", a, dst_mem[a], (a == 5) ? 200 : 0);
            end
        end
    endtask

    task automatic test_edge();
        int cyc, bc;
        foreach (src_mem[a]) src_mem[a] = ((a % W) >= 2) ? 100 : 0;
        run_frame(3, cyc, bc);
        for (int a = 0; a < NPIX; a++) begin
            total++;
            if (dst_mem[a] !== (((a % W) == 1 || (a % W) == 2) ? 255 : 0) || wr_epoch[a] !== epoch) begin
                bad++;
                $display("FAIL edge_pix[%0d]: got %0d want %0d", a, dst_mem[a],
                         ((a % W) == 1 || (a % W) == 2) ? 255 : 0);
            end
        end
    endtask

    task automatic test_random();
        int cyc, bc, m;
        for (int f = 0; f < 8; f++) begin
            m = (f < 4) ? f : int'($urandom_range(3, 0));
            foreach (src_mem[a]) src_mem[a] = int'($urandom_range(255, 0));
            run_frame(m, cyc, bc);
            total++;
            if (cyc !== 120) begin bad++; $display("FAIL rand_latency%0d: got %0d want 120", f, cyc); end
            for (int a = 0; a < NPIX; a++) begin
                total++;
                if (dst_mem[a] !== ref_pix(m, a % W, a / W) || wr_epoch[a] !== epoch) begin
                    bad++;
                    $display("FAIL rand%0d_mode%0d_pix[%0d]: got %0d want %0d",
                             f, m, a, dst_mem[a], ref_pix(m, a % W, a / W));
                end
            end
        end
    endtask

    task automatic test_abort();
        int base, k, extra_we, extra_done, cyc, bc, m;
        m = int'($urandom_range(3, 0));
        foreach (src_mem[a]) src_mem[a] = int'($urandom_range(255, 0));
        base = wr_cnt;
        @(negedge clk);
        mode  = 2'(m);
        start = 1'b1;
        epoch++;
        @(negedge clk);
        start = 1'b0;
        // Fifth pixel starts a row: 12 + 3*6 cycles, then 9 reads, then WAIT
        for (k = 0; k < 39; k++) @(negedge clk);
        total++;
        if (busy !== 1'b1 || wr_cnt - base !== 4) begin
            bad++;
            $display("FAIL abort_pre: busy=%b writes=%0d want busy=1 writes=4", busy, wr_cnt - base);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || dst_we !== 1'b0) begin
            bad++;
            $display("FAIL abort_next: busy=%b we=%b want 0 0", busy, dst_we);
        end
        extra_we   = 0;
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (dst_we) extra_we++;
            if (done)   extra_done++;
        end
        total++;
        if (extra_we !== 0 || extra_done !== 0 || wr_cnt - base !== 4) begin
            bad++;
            $display("FAIL abort_quiet: we=%0d done=%0d writes=%0d want 0 0 4", extra_we, extra_done, wr_cnt - base);
        end
        for (int a = 0; a < NPIX; a++) begin
            total++;
            if ((a < 4) ? (dst_mem[a] !== ref_pix(m, a, 0) || wr_epoch[a] !== epoch) : (wr_epoch[a] === epoch)) begin
                bad++;
                $display("FAIL abort_dst[%0d]: got %0d epoch=%0d cur=%0d", a, dst_mem[a], wr_epoch[a], epoch);
            end
        end
        foreach (src_mem[a]) src_mem[a] = int'($urandom_range(255, 0));
        run_frame(m, cyc, bc);
        total++;
        if (cyc !== 120) begin bad++; $display("FAIL abort_restart_latency: got %0d want 120", cyc); end
        for (int a = 0; a < NPIX; a++) begin
            total++;
            if (dst_mem[a] !== ref_pix(m, a % W, a / W) || wr_epoch[a] !== epoch) begin
                bad++;
                $display("FAIL abort_restart_pix[%0d]: got %0d want %0d", a, dst_mem[a], ref_pix(m, a % W, a / W));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int cyc, bc;
        foreach (src_mem[a]) src_mem[a] = int'($urandom_range(255, 0));
        @(negedge clk);
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #2 btnC = 1'b0;
        #1;
        total++;
        if ({busy, done, dst_we} !== 3'b000 || src_addr !== '0 || dst_addr !== '0 || dst_din !== '0) begin
            bad++;
            $display("FAIL midrun_reset_async: busy=%b done=%b we=%b src=%0d dst=%0d din=%0d, want all 0",
                     busy, done, dst_we, src_addr, dst_addr, dst_din);
        end
        repeat (3) @(negedge clk);
        btnC = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (rst_we_cnt !== 0 || busy !== 1'b0 || dst_we !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset_after: we_in_reset=%0d busy=%b we=%b want 0 0 0", rst_we_cnt, busy, dst_we);
        end
        run_frame(0, cyc, bc);
        total++;
        if (cyc !== 120) begin bad++; $display("FAIL midrun_recover_latency: got %0d want 120", cyc); end
    endtask

    task automatic test_ignored_starts();
        int base, cyc;
        base = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 1'b0 || wr_cnt !== base) begin
            bad++;
            $display("FAIL start_abort_idle: busy=%b writes=%0d want 0 0", busy, wr_cnt - base);
        end
        // Restart request and mode change in the middle of a copy run
        foreach (src_mem[a]) src_mem[a] = int'($urandom_range(255, 0));
        @(negedge clk);
        mode  = 2'd0;
        start = 1'b1;
        epoch++;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 2000) begin
            if (cyc == 30) begin start = 1'b1; mode = 2'd3; end
            if (cyc == 31) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 120) begin bad++; $display("FAIL busy_start_latency: got %0d want 120", cyc); end
        for (int a = 0; a < NPIX; a++) begin
            total++;
            if (dst_mem[a] !== src_mem[a] || wr_epoch[a] !== epoch) begin
                bad++;
                $display("FAIL busy_start_pix[%0d]: got %0d want %0d", a, dst_mem[a], src_mem[a]);
            end
        end
    endtask

    initial begin
        foreach (src_mem[a]) begin
            src_mem[a] = 0;
        end
        test_reset();
        test_copy_timing();
        test_box();
        test_sharpen();
        test_edge();
        test_random();
        test_abort();
        test_reset_midrun();
        test_ignored_starts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
